// File: rtl/alu_srcb_pkg.sv
// Shared types for the ALU operand-B source stage: source select codes and
// skid-buffer occupancy states.
package alu_srcb_pkg;

    typedef enum logic [2:0] {
        SRCB_B      = 3'd0,
        SRCB_INC    = 3'd1,
        SRCB_EXT    = 3'd2,
        SRCB_EXT_SH = 3'd3,
        SRCB_FWD    = 3'd4,
        SRCB_UPPER  = 3'd5
    } srcb_sel_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    localparam int SEL_W = 3;

endpackage

// File: rtl/srcb_skid_buffer.sv
// Two-entry valid/ready skid buffer; entry 0 is always the oldest beat and
// drives the outputs directly.
module srcb_skid_buffer
    import alu_srcb_pkg::*;
#(
    parameter int W = 35
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic         in_ready_q;
    logic         accept;
    logic         drain;

    assign accept      = in_valid_i & in_ready_q;
    assign drain       = (state_q != EMPTY) & out_ready_i;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = ent0_q;

    always_comb begin
        state_d = state_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    ent0_d  = in_data_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    ent0_d = in_data_i;
                end else if (accept) begin
                    ent1_d  = in_data_i;
                    state_d = TWO;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a drain can happen
                if (drain) begin
                    ent0_d  = ent1_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            ent0_q     <= '0;
            ent1_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            in_ready_q <= (state_d != TWO);
        end
    end

endmodule

// File: rtl/alu_srcb_stage.sv
// Registered ALU operand-B selector: extend/shift/select the source, tag it
// with the select code and pass it through a skid buffer so the ALU can stall.
module alu_srcb_stage
    import alu_srcb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 16,
    parameter int INC_CONST = 4,
    parameter int SHAMT     = 2,
    parameter int UPPER_SH  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [SEL_W-1:0]  srcb_sel_i,
    input  logic              imm_sext_i,
    input  logic [DATA_W-1:0] b_reg_i,
    input  logic [IMM_W-1:0]  imm_i,
    input  logic [DATA_W-1:0] fwd_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [SEL_W-1:0]  out_sel_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              illegal_sel_o
);

    localparam int PAY_W = DATA_W + SEL_W;

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] sel_data;
    logic              sel_illegal;
    logic [PAY_W-1:0]  pay_out;
    logic              illegal_q, illegal_d;
    logic              accept;

    assign imm_ext  = {{(DATA_W-IMM_W){imm_sext_i & imm_i[IMM_W-1]}}, imm_i};
    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm_i};

    always_comb begin
        sel_data    = '0;
        sel_illegal = 1'b0;
        case (srcb_sel_i)
            SRCB_B:      sel_data = b_reg_i;
            SRCB_INC:    sel_data = DATA_W'(INC_CONST);
            SRCB_EXT:    sel_data = imm_ext;
            SRCB_EXT_SH: sel_data = imm_ext << SHAMT;
            SRCB_FWD:    sel_data = fwd_data_i;
            SRCB_UPPER:  sel_data = imm_zext << UPPER_SH;
            default:     sel_illegal = 1'b1;
        endcase
    end

    assign accept    = in_valid_i & in_ready_o;
    assign illegal_d = illegal_q | (accept & sel_illegal);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_sel_o = illegal_q;

    srcb_skid_buffer #(
        .W (PAY_W)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   ({srcb_sel_i, sel_data}),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (pay_out),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    assign out_sel_o  = pay_out[PAY_W-1 -: SEL_W];
    assign out_data_o = pay_out[DATA_W-1:0];

endmodule
